freq_sorter: RTL and testbench
==============================

# freq_sorter

Stage directly downstream of the symbol frequency counter. Captures up to K_MAX (symbol, frequency) pairs delivered as single-cycle pulses, sorts them by ascending frequency (stable) once the counter signals completion, then streams the sorted list, one pair per cycle, to the Huffman tree/code-length stage.

## Interface
- K_MAX, 20, maximum number of distinct symbols held
- SW, 8, symbol width
- FW, 8, frequency width
- CW, 5, count width; must satisfy 2^CW > K_MAX
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- syml_pulse  in  1  one-cycle strobe: syml_in/freq_in valid
- syml_in  in  SW  symbol value
- freq_in  in  FW  symbol frequency
- fdone  in  1  counter-complete level; only its rising edge is used
- sort_valid  out  1  sort_syml/sort_freq valid this cycle
- sort_syml  out  SW  sorted symbol
- sort_freq  out  FW  sorted frequency
- sort_cnt  out  CW  number of valid entries; stable from SORT until the next LOAD begins
- sdone  out  1  one-cycle pulse after the last emitted pair
- busy  out  1  high in SORT and EMIT
- ovf  out  1  sticky: a pair was dropped; cleared only by reset

## Operation
- Storage: K_MAX entries of {symbol, frequency}, plus write count cnt (CW bits).
- fdone edge detect: internal fdone_q register; start = fdone & ~fdone_q. fdone_q resets to 0.
- States: LOAD (reset state), SORT, EMIT.
- LOAD:
  - syml_pulse with cnt < K_MAX: write entry[cnt]; cnt++.
  - syml_pulse with cnt == K_MAX: drop the pair; set ovf.
  - start: go to SORT. If start and syml_pulse occur in the same cycle, the pair is captured first.
  - start with a final cnt of 0: skip SORT and EMIT; pulse sdone on the next cycle; remain in LOAD.
- SORT:
  - Odd-even transposition sort, fixed K_MAX phases, phase counter 0..K_MAX-1.
  - Even phase compares pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),....
  - A pair (i,i+1) participates only if i+1 < cnt.
  - Swap only if freq[i] > freq[i+1] (strict), so equal frequencies keep arrival order.
  - After phase K_MAX-1, go to EMIT with read index 0.
- EMIT:
  - Each cycle: sort_valid=1 and drive entry[idx]; idx++.
  - After idx cnt-1 is emitted, the next cycle drops sort_valid, pulses sdone, clears cnt and idx, and returns to LOAD.
- syml_pulse in SORT or EMIT: ignored and sets ovf. start in SORT or EMIT: ignored.
- Frequency 0 on input is stored and sorted like any other value.
- No arithmetic is performed on frequencies; comparison is unsigned FW-bit.

## Timing
- Reset values:
  - sort_valid, sdone, busy, ovf = 0
  - sort_syml, sort_freq, sort_cnt = 0
  - state = LOAD; cnt, idx, phase, fdone_q = 0
  - entry contents don't-care
- Reset asserted mid-SORT or mid-EMIT: outputs return to reset values asynchronously; the sorted list is lost.
- Let start be sampled at edge T (cnt = N > 0 after that edge):
  - busy=1 from T+1 through T+K_MAX+N.
  - SORT phases run at T+1 .. T+K_MAX.
  - sort_valid=1 at T+K_MAX+1 .. T+K_MAX+N.
  - sdone=1 and busy=0 at T+K_MAX+N+1.
- Total latency from start to first output: K_MAX+1 cycles, independent of N.
- sort_syml/sort_freq hold their last value when sort_valid=0.
- No backpressure: downstream must accept one pair per cycle during EMIT.

## Test plan
- Basic sort: pairs (0x41,5),(0x42,2),(0x43,9),(0x44,1), then fdone rises → emitted order 0x44/1, 0x42/2, 0x41/5, 0x43/9; sort_cnt=4; first sort_valid 21 cycles after start; sdone 25 cycles after start.
- Stability: (0x10,3),(0x11,3),(0x12,1),(0x13,3) → 0x12/1, 0x10/3, 0x11/3, 0x13/3.
- Full and overflow: 21 pulses with freq 20..0 (K_MAX=20) → ovf=1; the 21st pair is absent; output is frequencies 1..20 ascending with 20 valid cycles.
- Edge cases: syml_pulse coincident with the fdone rise is included in the sort; fdone held high afterwards does not retrigger; fdone rise with no pairs → sdone one cycle later, sort_valid never asserts.
- Reset mid-EMIT: assert reset after the 2nd valid output → all outputs 0 immediately; a new load after deassertion sorts correctly with ovf=0.

Source files
------------

// File: rtl/freq_sorter.sv
// freq_sorter: captures up to K_MAX (symbol, frequency) pairs, sorts them by ascending frequency
// with a stable odd-even transposition sort once fdone rises, then streams the sorted list out
// one pair per cycle.
module freq_sorter #(
  parameter int unsigned K_MAX = 20,
  parameter int unsigned SW    = 8,
  parameter int unsigned FW    = 8,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          syml_pulse,
  input  logic [SW-1:0] syml_in,
  input  logic [FW-1:0] freq_in,
  input  logic          fdone,
  output logic          sort_valid,
  output logic [SW-1:0] sort_syml,
  output logic [FW-1:0] sort_freq,
  output logic [CW-1:0] sort_cnt,
  output logic          sdone,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {StLoad, StSort, StEmit} state_e;

  localparam logic [CW-1:0] KMax      = CW'(K_MAX);
  localparam logic [CW-1:0] LastPhase = CW'(K_MAX - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          fdone_q;
  logic          ovf_q, ovf_d;
  logic          sdone_q, sdone_d;
  logic [SW-1:0] hold_syml_q, hold_syml_d;
  logic [FW-1:0] hold_freq_q, hold_freq_d;
  logic          start;

  // Entry storage; contents are meaningless until written, so no reset.
  logic [SW-1:0] sym_q [K_MAX];
  logic [SW-1:0] sym_d [K_MAX];
  logic [FW-1:0] frq_q [K_MAX];
  logic [FW-1:0] frq_d [K_MAX];

  assign start = fdone & ~fdone_q;

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      idx_q       <= '0;
      phase_q     <= '0;
      fdone_q     <= 1'b0;
      ovf_q       <= 1'b0;
      sdone_q     <= 1'b0;
      hold_syml_q <= '0;
      hold_freq_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      fdone_q     <= fdone;
      ovf_q       <= ovf_d;
      sdone_q     <= sdone_d;
      hold_syml_q <= hold_syml_d;
      hold_freq_q <= hold_freq_d;
    end
  end

  // Entry array update (capture in LOAD, compare-exchange in SORT).
  always_ff @(posedge clk) begin
    sym_q <= sym_d;
    frq_q <= frq_d;
  end

  // Next-state logic: load, sort phases and emit sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    ovf_d       = ovf_q;
    sdone_d     = 1'b0;
    hold_syml_d = hold_syml_q;
    hold_freq_d = hold_freq_q;
    sym_d       = sym_q;
    frq_d       = frq_q;

    unique case (state_q)
      StLoad: begin
        if (syml_pulse) begin
          if (cnt_q < KMax) begin
            sym_d[cnt_q] = syml_in;
            frq_d[cnt_q] = freq_in;
            cnt_d        = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // cnt_d already includes a pair captured in this same cycle.
        if (start) begin
          if (cnt_d == '0) begin
            sdone_d = 1'b1;
          end else begin
            state_d = StSort;
            phase_d = '0;
          end
        end
      end

      StSort: begin
        if (syml_pulse) begin
          ovf_d = 1'b1;
        end
        // Pairs within one phase are disjoint, so every exchange reads only the _q values.
        for (int unsigned i = 0; i + 1 < K_MAX; i++) begin
          if (((i % 2) == 32'(phase_q[0])) && ((i + 1) < 32'(cnt_q)) &&
              (frq_q[i] > frq_q[i+1])) begin
            sym_d[i]   = sym_q[i+1];
            frq_d[i]   = frq_q[i+1];
            sym_d[i+1] = sym_q[i];
            frq_d[i+1] = frq_q[i];
          end
        end
        if (phase_q == LastPhase) begin
          state_d = StEmit;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end

      StEmit: begin
        if (syml_pulse) begin
          ovf_d = 1'b1;
        end
        hold_syml_d = sym_q[idx_q];
        hold_freq_d = frq_q[idx_q];
        if (idx_q == cnt_q - CW'(1)) begin
          state_d = StLoad;
          sdone_d = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // Outputs: live entry while emitting, otherwise the last emitted pair is held.
  always_comb begin
    sort_valid = (state_q == StEmit);
    busy       = (state_q != StLoad);
    sort_syml  = sort_valid ? sym_q[idx_q] : hold_syml_q;
    sort_freq  = sort_valid ? frq_q[idx_q] : hold_freq_q;
    sort_cnt   = cnt_q;
    sdone      = sdone_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_freq_sorter.sv
// Self-checking bench for freq_sorter: directed scenarios plus randomized loads checked against a
// queue-based stable insertion-sort model.
module tb_freq_sorter;

  localparam int K_MAX = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       syml_pulse = 1'b0;
  logic [7:0] syml_in = '0;
  logic [7:0] freq_in = '0;
  logic       fdone = 1'b0;
  logic       sort_valid, sdone, busy, ovf;
  logic [7:0] sort_syml, sort_freq;
  logic [4:0] sort_cnt;

  freq_sorter #(.K_MAX(K_MAX), .SW(8), .FW(8), .CW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .syml_pulse (syml_pulse),
    .syml_in    (syml_in),
    .freq_in    (freq_in),
    .fdone      (fdone),
    .sort_valid (sort_valid),
    .sort_syml  (sort_syml),
    .sort_freq  (sort_freq),
    .sort_cnt   (sort_cnt),
    .sdone      (sdone),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Captured output stream
  logic [7:0] got_sym[$];
  logic [7:0] got_frq[$];
  logic [4:0] got_cnt[$];
  int first_k, sdone_k, busy_first, busy_last, busy_cycles;
  logic sdone_after;

  // Reference model
  logic [7:0] exp_sym[$];
  logic [7:0] exp_frq[$];

  function automatic void model_clear();
    exp_sym.delete();
    exp_frq.delete();
  endfunction

  // Stable ascending insert; pairs beyond K_MAX are dropped.
  function automatic void model_add(input logic [7:0] s, input logic [7:0] f);
    int p;
    if (exp_sym.size() >= K_MAX) return;
    p = exp_frq.size();
    for (int j = 0; j < exp_frq.size(); j++) begin
      if (exp_frq[j] > f) begin
        p = j;
        break;
      end
    end
    exp_sym.insert(p, s);
    exp_frq.insert(p, f);
  endfunction

  // First position where the captured stream differs from the model, -2 on length, -1 if equal.
  function automatic int list_diff();
    if (got_sym.size() != exp_sym.size()) return -2;
    for (int j = 0; j < got_sym.size(); j++) begin
      if (got_sym[j] !== exp_sym[j] || got_frq[j] !== exp_frq[j]) return j;
    end
    return -1;
  endfunction

  // Number of valid cycles whose sort_cnt differed from n.
  function automatic int cnt_errors(input int n);
    int e = 0;
    foreach (got_cnt[j]) if (int'(got_cnt[j]) != n) e++;
    return e;
  endfunction

  task automatic pulse_pair(input logic [7:0] s, input logic [7:0] f);
    syml_pulse = 1'b1;
    syml_in    = s;
    freq_in    = f;
    @(negedge clk);
    syml_pulse = 1'b0;
  endtask

  // Samples at negedges; k=1 is the first cycle after the edge that sampled start.
  task automatic collect(input int budget);
    got_sym.delete(); got_frq.delete(); got_cnt.delete();
    first_k = -1; sdone_k = -1; busy_first = -1; busy_last = -1; busy_cycles = 0;
    sdone_after = 1'bx;
    for (int k = 1; k <= budget; k++) begin
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
        busy_cycles++;
      end
      if (sort_valid) begin
        if (first_k < 0) first_k = k;
        got_sym.push_back(sort_syml);
        got_frq.push_back(sort_freq);
        got_cnt.push_back(sort_cnt);
      end
      if (sdone) begin
        sdone_k = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    sdone_after = sdone;
  endtask

  task automatic start_and_collect();
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    collect(200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sort_valid, sdone, busy, ovf, sort_syml, sort_freq, sort_cnt} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {sort_valid, sdone, busy, ovf, sort_syml, sort_freq, sort_cnt});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sort_valid, sdone, busy, ovf} !== 4'd0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 0000", {sort_valid, sdone, busy, ovf});
    end
  endtask

  task automatic test_basic();
    int d;
    pulse_pair(8'h41, 8'd5);
    pulse_pair(8'h42, 8'd2);
    pulse_pair(8'h43, 8'd9);
    pulse_pair(8'h44, 8'd1);
    exp_sym = '{8'h44, 8'h42, 8'h41, 8'h43};
    exp_frq = '{8'd1, 8'd2, 8'd5, 8'd9};
    start_and_collect();
    d = list_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL basic_order: diff at %0d, got %0d items want 4", d, got_sym.size());
    end
    n_cmp++;
    if (first_k != 21) begin
      n_err++;
      $display("FAIL basic_first_valid: got %0d want 21", first_k);
    end
    n_cmp++;
    if (sdone_k != 25) begin
      n_err++;
      $display("FAIL basic_sdone: got %0d want 25", sdone_k);
    end
    n_cmp++;
    if (busy_first != 1 || busy_last != 24 || busy_cycles != 24) begin
      n_err++;
      $display("FAIL basic_busy: got %0d..%0d (%0d) want 1..24 (24)",
               busy_first, busy_last, busy_cycles);
    end
    n_cmp++;
    if (cnt_errors(4) != 0 || got_cnt.size() != 4) begin
      n_err++;
      $display("FAIL basic_sort_cnt: got %0d bad of %0d want 0 of 4",
               cnt_errors(4), got_cnt.size());
    end
    n_cmp++;
    if (sdone_after !== 1'b0 || sort_syml !== 8'h43 || sort_freq !== 8'd9) begin
      n_err++;
      $display("FAIL basic_hold: got sdone=%b %h/%0d want 0 43/9",
               sdone_after, sort_syml, sort_freq);
    end
  endtask

  task automatic test_stability();
    int d;
    pulse_pair(8'h10, 8'd3);
    pulse_pair(8'h11, 8'd3);
    pulse_pair(8'h12, 8'd1);
    pulse_pair(8'h13, 8'd3);
    exp_sym = '{8'h12, 8'h10, 8'h11, 8'h13};
    exp_frq = '{8'd1, 8'd3, 8'd3, 8'd3};
    start_and_collect();
    d = list_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL stability_order: diff at %0d, got %0d items want 4", d, got_sym.size());
    end
  endtask

  task automatic test_coincident();
    int d;
    int stray = 0;
    pulse_pair(8'h20, 8'd7);
    pulse_pair(8'h21, 8'd0);
    pulse_pair(8'h22, 8'd4);
    syml_pulse = 1'b1; syml_in = 8'h23; freq_in = 8'd2; fdone = 1'b1;
    @(negedge clk);
    syml_pulse = 1'b0;
    collect(200);
    exp_sym = '{8'h21, 8'h23, 8'h22, 8'h20};
    exp_frq = '{8'd0, 8'd2, 8'd4, 8'd7};
    d = list_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL coincident_order: diff at %0d, got %0d items want 4", d, got_sym.size());
    end
    n_cmp++;
    if (sdone_k != 25) begin
      n_err++;
      $display("FAIL coincident_sdone: got %0d want 25", sdone_k);
    end
    for (int k = 0; k < 30; k++) begin
      if (busy || sort_valid || sdone) stray++;
      @(negedge clk);
    end
    n_cmp++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL fdone_held_retrigger: got %0d active cycles want 0", stray);
    end
    fdone = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    start_and_collect();
    n_cmp++;
    if (sdone_k != 1 || got_sym.size() != 0 || busy_cycles != 0) begin
      n_err++;
      $display("FAIL empty_start: got sdone_k=%0d valid=%0d busy=%0d want 1 0 0",
               sdone_k, got_sym.size(), busy_cycles);
    end
  endtask

  task automatic test_random(input int rounds);
    int n, d;
    logic [7:0] s, f;
    for (int r = 0; r < rounds; r++) begin
      model_clear();
      n = (r == rounds - 1) ? K_MAX : int'($urandom_range(1, K_MAX));
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        s = 8'($urandom);
        f = r[0] ? 8'($urandom_range(0, 3)) : 8'($urandom);
        pulse_pair(s, f);
        model_add(s, f);
      end
      start_and_collect();
      d = list_diff();
      n_cmp++;
      if (d != -1) begin
        n_err++;
        $display("FAIL random_order[%0d]: diff at %0d, got %0d items want %0d",
                 r, d, got_sym.size(), n);
      end
      n_cmp++;
      if (first_k != K_MAX + 1 || sdone_k != K_MAX + 1 + n || busy_last != K_MAX + n) begin
        n_err++;
        $display("FAIL random_timing[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", r, first_k,
                 sdone_k, busy_last, K_MAX + 1, K_MAX + 1 + n, K_MAX + n);
      end
      n_cmp++;
      if (cnt_errors(n) != 0 || ovf !== 1'b0) begin
        n_err++;
        $display("FAIL random_cnt_ovf[%0d]: got %0d bad cnt, ovf=%b want 0, 0",
                 r, cnt_errors(n), ovf);
      end
    end
  endtask

  task automatic test_overflow();
    int d;
    model_clear();
    for (int j = 0; j <= K_MAX; j++) begin
      pulse_pair(8'(8'h80 + j), 8'(K_MAX - j));
      model_add(8'(8'h80 + j), 8'(K_MAX - j));
    end
    start_and_collect();
    d = list_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL overflow_order: diff at %0d, got %0d items want %0d", d, got_sym.size(),
               K_MAX);
    end
    n_cmp++;
    if (got_frq.size() != K_MAX || got_frq[0] !== 8'd1 || sdone_k != 2 * K_MAX + 1) begin
      n_err++;
      $display("FAIL overflow_len: got %0d items sdone_k=%0d want %0d items sdone_k=%0d",
               got_frq.size(), sdone_k, K_MAX, 2 * K_MAX + 1);
    end
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_flag: got %b want 1", ovf);
    end
  endtask

  task automatic test_reset_mid_emit();
    int v = 0;
    int d;
    logic [7:0] s, f;
    for (int j = 0; j < 5; j++) pulse_pair(8'(j + 1), 8'($urandom));
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sort_valid) v++;
      if (v == 2) break;
      @(negedge clk);
    end
    n_cmp++;
    if (v != 2) begin
      n_err++;
      $display("FAIL mid_emit_reach: got %0d valid want 2", v);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sort_valid, sdone, busy, ovf, sort_syml, sort_freq, sort_cnt} !== 25'd0) begin
      n_err++;
      $display("FAIL mid_emit_reset: got %h want 0",
               {sort_valid, sdone, busy, ovf, sort_syml, sort_freq, sort_cnt});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    for (int j = 0; j < 6; j++) begin
      s = 8'($urandom);
      f = 8'($urandom_range(0, 5));
      pulse_pair(s, f);
      model_add(s, f);
    end
    start_and_collect();
    d = list_diff();
    n_cmp++;
    if (d != -1 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_sort: diff at %0d, ovf=%b want -1, 0", d, ovf);
    end
  endtask

  task automatic test_pulse_while_busy();
    int d;
    pulse_pair(8'h01, 8'd9);
    pulse_pair(8'h02, 8'd4);
    fdone = 1'b1;
    @(negedge clk);
    fdone = 1'b0;
    pulse_pair(8'h03, 8'd0);
    collect(200);
    exp_sym = '{8'h02, 8'h01};
    exp_frq = '{8'd4, 8'd9};
    d = list_diff();
    n_cmp++;
    if (d != -1 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL busy_pulse: diff at %0d, ovf=%b want -1, 1", d, ovf);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stability();
    test_coincident();
    test_empty();
    test_random(4);
    test_overflow();
    test_reset_mid_emit();
    test_pulse_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
